// File: rtl/uart_pkg.sv
// Shared parity-mode codes, transmitter state type and parity helpers.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Mode 2'b11 is an alias for no parity.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  function automatic logic parity_invert(input logic [1:0] mode);
    return (mode == PAR_ODD) && (mode != PAR_NONE);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX FIFO.
//   clk, reset (sync, active-low); push/wdata write when not full;
//   pop advances the head when not empty; rdata shows the head;
//   full, empty, count report occupancy.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with TX FIFO and internal bit-period counter.
//   clk, reset (sync, active-low); in_valid/in_data/in_ready host push;
//   p_mode parity select; tx serial line; busy, tx_done, fifo_count status.
module uart_tx_param #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          in_ready,
  input  logic [1:0]                    p_mode,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  import uart_pkg::*;

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);

  tx_state_t            state;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_en;
  logic                 par_bit;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_rdata;

  logic                 bit_last;
  logic                 stop_last;
  logic                 frame_end;

  assign in_ready  = reset && !fifo_full;
  assign bit_last  = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign stop_last = (stop_idx == 1'(STOP_BITS - 1));
  assign frame_end = (state == ST_STOP) && bit_last && stop_last;
  assign tx_done   = frame_end;
  assign busy      = (state != ST_IDLE) || (fifo_count != '0);
  assign fifo_pop  = ((state == ST_IDLE) || frame_end) && !fifo_empty;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid && in_ready),
    .wdata (in_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // tx is registered with the value for the state being entered, so the
  // line changes exactly on the edge that starts each bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      if (state == ST_IDLE || bit_last) begin
        clk_cnt <= '0;
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end

      if (fifo_pop) begin
        shift    <= fifo_rdata;
        par_en   <= parity_enabled(p_mode);
        par_bit  <= (^fifo_rdata) ^ parity_invert(p_mode);
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        state    <= ST_START;
        tx       <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            tx <= 1'b1;
          end
          ST_START: begin
            if (bit_last) begin
              state <= ST_DATA;
              tx    <= shift[0];
            end
          end
          ST_DATA: begin
            if (bit_last) begin
              if (bit_idx == BW'(DATA_BITS - 1)) begin
                if (par_en) begin
                  state <= ST_PARITY;
                  tx    <= par_bit;
                end else begin
                  state <= ST_STOP;
                  tx    <= 1'b1;
                end
              end else begin
                bit_idx <= bit_idx + 1'b1;
                shift   <= {1'b0, shift[DATA_BITS-1:1]};
                tx      <= shift[1];
              end
            end
          end
          ST_PARITY: begin
            if (bit_last) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end
          end
          ST_STOP: begin
            tx <= 1'b1;
            if (bit_last) begin
              if (stop_last) begin
                state <= ST_IDLE;
              end else begin
                stop_idx <= stop_idx + 1'b1;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;

  localparam int unsigned CPB = 4;

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, rst2_n;
  logic       in_valid, in_valid2;
  logic [7:0] in_data, in_data2;
  logic       in_ready, in_ready2;
  logic [1:0] p_mode, p_mode2;
  logic       tx, tx2;
  logic       busy, busy2;
  logic       tx_done, tx_done2;
  logic [2:0] fifo_count, fifo_count2;

  always #5 clk = ~clk;

  uart_tx_param #(
    .DATA_BITS    (8),
    .STOP_BITS    (1),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .p_mode     (p_mode),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .fifo_count (fifo_count)
  );

  uart_tx_param #(
    .DATA_BITS    (8),
    .STOP_BITS    (2),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut2 (
    .clk        (clk),
    .reset      (rst2_n),
    .in_valid   (in_valid2),
    .in_data    (in_data2),
    .in_ready   (in_ready2),
    .p_mode     (p_mode2),
    .tx         (tx2),
    .busy       (busy2),
    .tx_done    (tx_done2),
    .fifo_count (fifo_count2)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Scoreboard and line monitor for the single-stop-bit instance.
  exp_t        sb[$];
  bit          mon_en = 1'b0;
  bit          in_frame = 1'b0;
  bit          gap_chk = 1'b0;
  int unsigned gap_base = 0;
  int unsigned frames_done = 0;
  int unsigned neg_cnt = 0;
  int unsigned last_end = 0;
  int unsigned pos = 0;
  int unsigned exp_len = 0;
  logic [15:0] exp_bits;
  exp_t        cur;

  always @(negedge clk) begin
    neg_cnt++;
    if (!mon_en) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && tx === 1'b0) begin
        if (sb.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          cur         = sb.pop_front();
          exp_bits    = '1;
          exp_bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) exp_bits[1+i] = cur.data[i];
          exp_len = 9;
          if (cur.mode == 2'b01 || cur.mode == 2'b10) begin
            exp_bits[exp_len] = (^cur.data) ^ (cur.mode == 2'b10);
            exp_len++;
          end
          exp_bits[exp_len] = 1'b1;
          exp_len++;
          if (gap_chk && frames_done > gap_base) chk("frame_gap", neg_cnt - last_end, 1);
          in_frame = 1'b1;
          pos      = 0;
        end
      end else if (!in_frame && tx_done === 1'b1) begin
        chk("stray_tx_done", tx_done, 0);
      end
      if (in_frame) begin
        chk("tx_bit", tx, exp_bits[pos / CPB]);
        chk("tx_done", tx_done, pos == exp_len * CPB - 1);
        if (pos == exp_len * CPB - 1) begin
          in_frame = 1'b0;
          frames_done++;
          last_end = neg_cnt;
        end else begin
          pos++;
        end
      end
    end
  end

  task automatic push(input logic [7:0] d);
    int unsigned guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("push_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      sb.push_back('{d, p_mode});
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_frames(input int unsigned target);
    int unsigned g = 0;
    while (frames_done < target && g < 3000) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("frames_done", frames_done, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lows;
    int unsigned g;
    rst_n = 1'b0; rst2_n = 1'b0;
    in_valid = 1'b0; in_valid2 = 1'b0;
    in_data = '0; in_data2 = '0;
    p_mode = 2'b00; p_mode2 = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", in_ready, 0);
    rst_n = 1'b1; rst2_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);

    // Plain frame and first-bit latency.
    p_mode = 2'b00;
    push(8'hA5);
    @(negedge clk);
    chk("lat_tx_before_pop", tx, 1);
    chk("lat_count", fifo_count, 1);
    chk("lat_busy", busy, 1);
    @(negedge clk);
    chk("lat_tx_start", tx, 0);
    wait_frames(1);
    @(negedge clk);
    chk("a5_busy_after", busy, 0);

    // Even and odd parity.
    p_mode = 2'b01;
    push(8'h03);
    wait_frames(2);
    p_mode = 2'b10;
    push(8'h03);
    wait_frames(3);
    p_mode = 2'b11;
    push(8'h81);
    wait_frames(4);
    @(negedge clk);

    // Back-to-back frames and FIFO full.
    p_mode   = 2'b01;
    gap_base = frames_done;
    gap_chk  = 1'b1;
    push(8'h11);
    push(8'h22);
    push(8'h3C);
    push(8'h47);
    push(8'hF0);
    @(negedge clk);
    chk("full_ready", in_ready, 0);
    chk("full_count", fifo_count, 4);
    wait_frames(9);
    gap_chk = 1'b0;
    @(negedge clk);
    chk("b2b_count", fifo_count, 0);
    chk("b2b_busy", busy, 0);
    chk("b2b_sb_empty", sb.size(), 0);

    // Reset mid-frame with two entries queued.
    p_mode = 2'b00;
    push(8'h96);
    push(8'h55);
    push(8'hAA);
    repeat (12) @(negedge clk);
    chk("pre_rst_count", fifo_count, 2);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("post_rst_quiet", lows, 0);
    chk("post_rst_busy", busy, 0);
    mon_en = 1'b1;
    p_mode = 2'b10;
    push(8'h5A);
    wait_frames(10);

    // Two-stop-bit build.
    @(negedge clk);
    in_valid2 = 1'b1;
    in_data2  = 8'hFF;
    chk("s2_ready", in_ready2, 1);
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    g = 0;
    @(negedge clk);
    while (tx2 !== 1'b0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("s2_start_seen", tx2, 0);
    for (int i = 0; i < 44; i++) begin
      chk("s2_tx", tx2, (i < 4) ? 0 : 1);
      chk("s2_done", tx_done2, i == 43);
      if (i != 43) @(negedge clk);
    end
    @(negedge clk);
    chk("s2_busy_after", busy2, 0);
    chk("s2_tx_idle", tx2, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
